dmem_responder: RTL and testbench

//  Data-memory responder: the target side of the load/store port that the pipelined CPU's MEM stage drives.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_responder_fifo.sv | 53 +++++
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state, word geometry and the response FIFO entry.
package dmem_pkg;

  typedef enum logic {INIT, RUN} dmem_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_entry_t;

endpackage

// File: rtl/dmem_responder_fifo.sv
// Synchronous FIFO with an extra pointer wrap bit so full and empty are distinguishable.
// A push into a full FIFO is accepted only together with a pop.
module resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [32:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  T            storage [DEPTH];
  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                    (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = storage[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr_reg[PW-1:0]] <= push_data;
  end

`ifndef SYNTHESIS
  // Credit flow control upstream must make this unreachable.
  overflow_a: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-fill FSM, byte-lane word array, fixed-latency load pipeline and credited response FIFO.
// Optional build macro DMEM_MISALIGN_ERR_EN: misaligned accesses skip the array and loads return an error response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int NWORDS = 1 << ADDR_W;
  localparam int CW     = $clog2(RESP_DEPTH + 1);
  localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

  dmem_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] fill_addr_reg, fill_addr_next;
  logic              init_we;
  logic [CW-1:0]     credits_reg, credits_next;

  logic [WORD_W-1:0] mem [NWORDS];
  logic [WORD_W-1:0] rd_data_reg;
  logic [WORD_W-1:0] data_pipe_reg [PIPE_N];
  logic [WORD_W-1:0] tail_data;
  logic [LATENCY-1:0] pipe_valid_reg;
  logic [LATENCY-1:0] pipe_err_reg;

  logic              accept, load_acc, store_acc, misaligned;
  logic [ADDR_W-1:0] word_idx;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be, lane_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  resp_entry_t       push_entry, head_entry;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(RESP_DEPTH):0] fifo_count;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= INIT;
      fill_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fill_addr_reg <= fill_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fill_addr_next = fill_addr_reg;
    init_we        = 1'b0;
    case (state_reg)
      INIT: begin
        init_we        = 1'b1;
        fill_addr_next = fill_addr_reg + 1'b1;
        if (fill_addr_reg == {ADDR_W{1'b1}}) state_next = RUN;
      end
      RUN:     ;
      default: state_next = INIT;
    endcase
  end

  assign init_done = (state_reg == RUN);

  // ---------------- request side ----------------
  assign req_ready = (state_reg == RUN) && (credits_reg != '0);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
  logic [15:0] err_count_reg;

  assign misaligned = (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count_reg <= '0;
    end else if (accept && req_we && misaligned && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign load_acc  = accept && !req_we;
  assign store_acc = accept && req_we && !misaligned;

  // Zero-fill owns the write port during INIT; requests cannot be accepted then.
  assign mem_we    = init_we || store_acc;
  assign mem_be    = init_we ? {BE_W{1'b1}} : req_be;
  assign mem_waddr = init_we ? fill_addr_reg : word_idx;
  assign mem_wdata = init_we ? '0 : req_wdata;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign lane_we[gi] = mem_we && mem_be[gi];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (lane_we[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (load_acc) rd_data_reg <= mem[word_idx];
  end

  // ---------------- load pipeline ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_valid_reg <= '0;
      pipe_err_reg   <= '0;
    end else begin
      pipe_valid_reg[0] <= load_acc;
      pipe_err_reg[0]   <= misaligned;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_err_reg[i]   <= pipe_err_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_pipe_reg[0] <= rd_data_reg;
    for (int i = 1; i < PIPE_N; i++) data_pipe_reg[i] <= data_pipe_reg[i-1];
  end

  if (LATENCY == 1) begin : g_tail_rd
    assign tail_data = rd_data_reg;
  end else begin : g_tail_pipe
    assign tail_data = data_pipe_reg[LATENCY-2];
  end

  assign fifo_push        = pipe_valid_reg[LATENCY-1];
  assign push_entry.err   = pipe_err_reg[LATENCY-1];
  assign push_entry.rdata = pipe_err_reg[LATENCY-1] ? '0 : tail_data;

  // ---------------- response FIFO and credits ----------------
  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (resp_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign fifo_pop   = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? head_entry.rdata : '0;
  assign resp_err   = resp_valid ? head_entry.err : 1'b0;

  always_comb begin
    credits_next = credits_reg;
    case ({load_acc, fifo_pop})
      2'b10:   credits_next = credits_reg - 1'b1;
      2'b01:   credits_next = credits_reg + 1'b1;
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) credits_reg <= CW'(RESP_DEPTH);
    else      credits_reg <= credits_next;
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], fifo_full, fifo_count};
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0], fifo_full, fifo_count};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters, optional DMEM_MISALIGN_ERR_EN).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output bit ok);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    ok = req_ready;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    int n;
    n = 0;
    while (!resp_valid && n < 50) begin
      tick();
      n++;
    end
    ok = resp_valid;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 3000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int  cyc;
    bit  early;
    bit  ok;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, resp_valid, resp_err, init_done} !== 4'b0000 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b valid=%b err=%b done=%b rdata=%h required all 0",
               req_ready, resp_valid, resp_err, init_done, resp_rdata);
    end
    rst = 1'b1;
    cyc = 0;
    early = 1'b0;
    while (!init_done && cyc < 3000) begin
      tick();
      cyc++;
      if (req_ready && !init_done) early = 1'b1;
    end
    checks++;
    if (cyc !== 1024) begin
      errors++;
      $display("FAIL init_cycles got %0d required 1024", cyc);
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_init got 1 required 0");
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init got %b required 1", req_ready);
    end
    resp_ready = 1'b1;
    send(1'b0, 32'h40, 32'h0, 4'h0, ok);
    wait_resp(ok);
    checks++;
    if (!ok || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL load_zero got valid=%b rdata=%h err=%b required 1 00000000 0", ok, resp_rdata, resp_err);
    end
    tick();
    $display("test_reset: init took %0d cycles", cyc);
  endtask

  task automatic test_store_load();
    bit ok;
    resp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, ok);
    send(1'b0, 32'h10, 32'h0, 4'h0, ok);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n got resp_valid=%b required 0", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1 got resp_valid=%b required 0", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL raw_full got valid=%b rdata=%h required 1 deadbeef", resp_valid, resp_rdata);
    end
    tick();
    send(1'b1, 32'h10, 32'h0000AA00, 4'b0010, ok);
    send(1'b0, 32'h10, 32'h0, 4'h0, ok);
    wait_resp(ok);
    checks++;
    if (!ok || resp_rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL byte_lane got valid=%b rdata=%h required deadaaef", ok, resp_rdata);
    end
    tick();
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, ok);
    send(1'b0, 32'h10, 32'h0, 4'h0, ok);
    wait_resp(ok);
    checks++;
    if (!ok || resp_rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL be_zero got valid=%b rdata=%h required deadaaef", ok, resp_rdata);
    end
    tick();
    // 0x1010 aliases word 4 (byte 0x10) because upper address bits are ignored
    send(1'b0, 32'h1010, 32'h0, 4'h0, ok);
    wait_resp(ok);
    checks++;
    if (!ok || resp_rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL addr_wrap got valid=%b rdata=%h required deadaaef", ok, resp_rdata);
    end
    tick();
    $display("test_store_load: done");
  endtask

  task automatic test_credits();
    bit          ok;
    logic [31:0] exp_data;
    for (int k = 0; k < 4; k++) send(1'b1, 32'h20 + 4 * k, 32'h11111111 * (k + 1), 4'hF, ok);
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 32'h20 + 4 * k, 32'h0, 4'h0, ok);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_exhaust got req_ready=%b required 0", req_ready);
    end
    repeat (3) tick();
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL credit_hold got ready=%b valid=%b rdata=%h required 0 1 11111111",
               req_ready, resp_valid, resp_rdata);
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_return got req_ready=%b required 1", req_ready);
    end
    for (int k = 1; k < 4; k++) begin
      exp_data = 32'h11111111 * (k + 1);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_data) begin
        errors++;
        $display("FAIL credit_order%0d got valid=%b rdata=%h required 1 %h", k, resp_valid, resp_rdata, exp_data);
      end
      tick();
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_drain got resp_valid=%b required 0", resp_valid);
    end
    $display("test_credits: done");
  endtask

  task automatic test_back_to_back();
    bit          ok, acc;
    int          issued, got, stall, first_acc, last_acc, first_resp, last_resp;
    logic [31:0] exp_data;
    for (int k = 0; k < 16; k++) send(1'b1, 32'h200 + 4 * k, 32'hC0DE0000 + k, 4'hF, ok);
    issued = 0; got = 0; stall = 0;
    first_acc = -1; last_acc = -1; first_resp = -1; last_resp = -1;
    resp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (issued < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200 + 4 * issued;
      end else begin
        req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
      if (req_valid && !req_ready) stall++;
      tick();
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        issued++;
      end
      if (resp_valid) begin
        exp_data = 32'hC0DE0000 + got;
        checks++;
        if (resp_rdata !== exp_data) begin
          errors++;
          $display("FAIL b2b_data%0d got %h required %h", got, resp_rdata, exp_data);
        end
        if (first_resp < 0) first_resp = c;
        last_resp = c;
        got++;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (got !== 16 || stall !== 0 || (last_acc - first_acc) !== 15 || (last_resp - first_resp) !== 15) begin
      errors++;
      $display("FAIL b2b_rate got responses=%0d stalls=%0d acc_span=%0d resp_span=%0d required 16 0 15 15",
               got, stall, last_acc - first_acc, last_resp - first_resp);
    end
    $display("test_back_to_back: %0d accepts, %0d responses", issued, got);
  endtask

  task automatic test_misalign();
    bit ok;
    resp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok);
    send(1'b0, 32'h13, 32'h0, 4'h0, ok);
    wait_resp(ok);
`ifdef DMEM_MISALIGN_ERR_EN
    checks++;
    if (!ok || resp_rdata !== 32'h0 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_load got valid=%b rdata=%h err=%b required 1 00000000 1", ok, resp_rdata, resp_err);
    end
    tick();
    send(1'b1, 32'h12, 32'h12345678, 4'hF, ok);
    send(1'b0, 32'h10, 32'h0, 4'h0, ok);
    wait_resp(ok);
    checks++;
    if (!ok || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_store got valid=%b rdata=%h err=%b required 1 deadbeef 0", ok, resp_rdata, resp_err);
    end
`else
    checks++;
    if (!ok || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_load got valid=%b rdata=%h err=%b required 1 deadbeef 0", ok, resp_rdata, resp_err);
    end
`endif
    tick();
    $display("test_misalign: done");
  endtask

  task automatic test_reset_midflight();
    bit ok, seen;
    int cyc;
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(1'b0, 32'h200 + 4 * k, 32'h0, 4'h0, ok);
    rst = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset got valid=%b ready=%b done=%b required 0 0 0", resp_valid, req_ready, init_done);
    end
    tick();
    rst = 1'b1;
    resp_ready = 1'b1;
    wait_init(cyc);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (cyc !== 1024 || seen !== 1'b0) begin
      errors++;
      $display("FAIL stale_resp got init_cycles=%0d stale=%b required 1024 0", cyc, seen);
    end
    $display("test_reset_midflight: init took %0d cycles", cyc);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_credits();
    test_back_to_back();
    test_misalign();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
